// File: rtl/l2_pri_bank_arbiter_if.sv
// Requester-side TCDM bus and SRAM-side bank port of the private L2 bank arbiter.
// The master modport is the environment (requesters plus SRAM); the slave modport is the arbiter.
interface l2_pri_bank_arbiter_if #(
   parameter int NB_REQ = 3,
   parameter int ADDR_W = 10
);
   logic [NB_REQ-1:0]        req_i;
   logic [NB_REQ-1:0][31:0]  add_i;
   logic [NB_REQ-1:0]        wen_i;
   logic [NB_REQ-1:0][31:0]  wdata_i;
   logic [NB_REQ-1:0][3:0]   be_i;
   logic [NB_REQ-1:0]        gnt_o;
   logic [NB_REQ-1:0]        r_valid_o;
   logic [NB_REQ-1:0][31:0]  r_rdata_o;

   logic                     bank_req_o;
   logic                     bank_we_o;
   logic [ADDR_W-1:0]        bank_addr_o;
   logic [31:0]              bank_wdata_o;
   logic [3:0]               bank_be_o;
   logic [31:0]              bank_rdata_i;

   modport master (
      output req_i, add_i, wen_i, wdata_i, be_i, bank_rdata_i,
      input  gnt_o, r_valid_o, r_rdata_o,
             bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o
   );

   modport slave (
      input  req_i, add_i, wen_i, wdata_i, be_i, bank_rdata_i,
      output gnt_o, r_valid_o, r_rdata_o,
             bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o
   );
endinterface

// File: rtl/l2_pri_bank_arbiter.sv
// Private L2 bank arbiter: requester 0 has priority, requesters 1..NB_REQ-1 share
// round-robin, and a starvation limit forces a low-priority grant after MAX_STARVE wins.
module l2_pri_bank_arbiter #(
   parameter int          NB_REQ     = 3,
   parameter int          BANK_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
   parameter int          MAX_STARVE = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   l2_pri_bank_arbiter_if.slave  bus,
   output logic [31:0]           conflict_cnt_o
);
   localparam int IDX_W  = $clog2(NB_REQ);
   localparam int ADDR_W = $clog2(BANK_WORDS);
   localparam int SW     = $clog2(MAX_STARVE + 1);

   logic [IDX_W-1:0] rr_ptr;
   logic [SW-1:0]    starve_cnt;
   logic [IDX_W-1:0] owner;
   logic             valid_q;

   logic             lo_pending;
   logic             hi_win;
   logic             any_gnt;
   logic [IDX_W-1:0] rr_win;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] sel;
   logic [31:0]      offset;
   int               idx;

   // NOTE: every combinational output gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rr_win = '0;
      idx    = 0;
      for (int off = NB_REQ - 2; off >= 0; off--) begin
         // Search downward so the lowest offset from rr_ptr wins last.
         idx = int'(rr_ptr) + off;
         if (idx >= NB_REQ) idx = idx - (NB_REQ - 1);
         if (bus.req_i[idx]) rr_win = IDX_W'(idx);
      end
   end

   assign lo_pending = |bus.req_i[NB_REQ-1:1];
   assign hi_win     = bus.req_i[0] && !(lo_pending && starve_cnt == SW'(MAX_STARVE));
   assign any_gnt    = hi_win || lo_pending;
   assign gnt_idx    = hi_win ? '0 : rr_win;
   assign bus.gnt_o  = any_gnt ? (NB_REQ'(1) << gnt_idx) : '0;

   // Idle cycles keep requester 0 on the bank mux so the SRAM inputs do not toggle.
   assign sel              = any_gnt ? gnt_idx : '0;
   assign offset           = bus.add_i[sel] - BASE_ADDR;
   assign bus.bank_req_o   = any_gnt;
   assign bus.bank_we_o    = ~bus.wen_i[sel];
   assign bus.bank_addr_o  = offset[ADDR_W+1:2];
   assign bus.bank_wdata_o = bus.wdata_i[sel];
   assign bus.bank_be_o    = bus.be_i[sel];

   assign bus.r_valid_o = NB_REQ'(valid_q) << owner;
   assign bus.r_rdata_o = {NB_REQ{bus.bank_rdata_i}};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr         <= IDX_W'(1);
         starve_cnt     <= '0;
         owner          <= '0;
         valid_q        <= 1'b0;
         conflict_cnt_o <= '0;
      end else begin
         valid_q <= any_gnt;
         if (any_gnt) owner <= gnt_idx;

         if (any_gnt && !hi_win)
            rr_ptr <= (int'(gnt_idx) == NB_REQ - 1) ? IDX_W'(1) : gnt_idx + IDX_W'(1);

         if (hi_win && lo_pending) begin
            if (starve_cnt != SW'(MAX_STARVE)) starve_cnt <= starve_cnt + SW'(1);
         end else begin
            starve_cnt <= '0;
         end

         if ($countones(bus.req_i) >= 2 && conflict_cnt_o != 32'hFFFF_FFFF)
            conflict_cnt_o <= conflict_cnt_o + 32'd1;
      end
   end
endmodule

// File: tb/tb_l2_pri_bank_arbiter.sv
// Directed bench for l2_pri_bank_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_l2_pri_bank_arbiter;
   localparam int          NB_REQ     = 3;
   localparam int          BANK_WORDS = 1024;
   localparam int          AW         = 10;
   localparam logic [31:0] BASE       = 32'h1C00_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] conflict_cnt;
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] mem [BANK_WORDS];

   always #5 clk = ~clk;

   l2_pri_bank_arbiter_if #(.NB_REQ(NB_REQ), .ADDR_W(AW)) bus ();

   l2_pri_bank_arbiter #(
      .NB_REQ(NB_REQ), .BANK_WORDS(BANK_WORDS), .BASE_ADDR(BASE), .MAX_STARVE(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus), .conflict_cnt_o(conflict_cnt)
   );

   always @(posedge clk) begin
      if (bus.bank_req_o) begin
         if (bus.bank_we_o) begin
            for (int b = 0; b < 4; b++)
               if (bus.bank_be_o[b]) mem[bus.bank_addr_o][8*b +: 8] <= bus.bank_wdata_o[8*b +: 8];
         end else begin
            bus.bank_rdata_i <= mem[bus.bank_addr_o];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input int k, input logic [31:0] a, input logic wen,
                        input logic [31:0] wd, input logic [3:0] be);
      bus.add_i[k]   = a;
      bus.wen_i[k]   = wen;
      bus.wdata_i[k] = wd;
      bus.be_i[k]    = be;
   endtask

   // Checks the combinational grant mid-cycle, then r_valid just after the edge.
   task automatic cycle(input string tag, input logic [2:0] exp_gnt);
      #3;
      check({tag, " gnt"}, 32'(bus.gnt_o), 32'(exp_gnt));
      check({tag, " bank_req"}, 32'(bus.bank_req_o), 32'(|exp_gnt));
      @(posedge clk); #1;
      check({tag, " r_valid"}, 32'(bus.r_valid_o), 32'(exp_gnt));
   endtask

   task automatic do_reset();
      bus.req_i = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   logic [2:0] rr_seq  [4]  = '{3'b010, 3'b100, 3'b010, 3'b100};
   logic [2:0] hi_seq  [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                                3'b001, 3'b001, 3'b001, 3'b001, 3'b010};

   initial begin
      rst_n = 1'b0;
      bus.req_i = '0;
      for (int k = 0; k < NB_REQ; k++) drive(k, BASE, 1'b1, '0, 4'hF);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("reset r_valid", 32'(bus.r_valid_o), 32'h0);
      check("reset conflict", conflict_cnt, 32'h0);
      check("reset gnt", 32'(bus.gnt_o), 32'h0);

      // Write then read back from requester 1.
      drive(1, BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
      bus.req_i = 3'b010;
      #2;
      check("wr bank_addr", 32'(bus.bank_addr_o), 32'd4);
      check("wr bank_we", 32'(bus.bank_we_o), 32'd1);
      check("wr bank_wdata", bus.bank_wdata_o, 32'hDEAD_BEEF);
      cycle("wr", 3'b010);
      drive(1, BASE + 32'h10, 1'b1, '0, 4'hF);
      #2;
      check("rd bank_we", 32'(bus.bank_we_o), 32'd0);
      check("rd bank_addr", 32'(bus.bank_addr_o), 32'd4);
      cycle("rd", 3'b010);
      check("rd rdata", bus.r_rdata_o[1], 32'hDEAD_BEEF);

      // Idle: grant, bank request and counter stay quiet; mux holds requester 0.
      bus.req_i = '0;
      drive(0, BASE + 32'h20, 1'b1, '0, 4'hF);
      #2;
      check("idle bank_addr", 32'(bus.bank_addr_o), 32'd8);
      cycle("idle", 3'b000);
      check("idle conflict", conflict_cnt, 32'h0);

      // Round-robin between requesters 1 and 2.
      do_reset();
      drive(1, BASE, 1'b1, '0, 4'hF);
      drive(2, BASE + 32'h4, 1'b1, '0, 4'hF);
      bus.req_i = 3'b110;
      foreach (rr_seq[i]) cycle($sformatf("rr%0d", i), rr_seq[i]);
      check("rr conflict", conflict_cnt, 32'd4);
      bus.req_i = '0;
      cycle("rr idle", 3'b000);
      check("rr idle conflict", conflict_cnt, 32'd4);

      // Priority port with starvation limit.
      do_reset();
      bus.req_i = 3'b011;
      foreach (hi_seq[i]) cycle($sformatf("starve%0d", i), hi_seq[i]);
      check("starve conflict", conflict_cnt, 32'd10);

      // Address wraps modulo the bank size.
      bus.req_i = 3'b100;
      drive(2, BASE + 4 * BANK_WORDS + 8, 1'b1, '0, 4'hF);
      #2;
      check("wrap bank_addr", 32'(bus.bank_addr_o), 32'd2);
      cycle("wrap", 3'b100);

      // Reset right after a read grant to requester 1 (which moves rr_ptr to 2).
      bus.req_i = 3'b010;
      #3;
      check("rst gnt", 32'(bus.gnt_o), 32'b010);
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.req_i = '0;
      #1;
      check("rst r_valid drop", 32'(bus.r_valid_o), 32'h0);
      @(posedge clk); #1;
      check("rst r_valid hold", 32'(bus.r_valid_o), 32'h0);
      rst_n = 1'b1;
      bus.req_i = 3'b110;
      cycle("post-rst", 3'b010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/l2_pri_bank_arbiter.md
Name: l2_pri_bank_arbiter

Overview:
- Shares one single-port private L2 SRAM bank (1-cycle read latency, word-addressed) between NB_REQ TCDM-style requesters.
- Requester 0 is the high-priority port (FC data). Requesters 1..NB_REQ-1 share round-robin, protected by a starvation limit.
- Sits between the SoC interconnect and a private-bank tc_sram. Removes the bank base-address offset and routes responses back to the owning requester.

Parameters:
- NB_REQ, 3, number of requesters; legal range 2..8.
- BANK_WORDS, 1024, bank depth in 32-bit words.
- BASE_ADDR, 32'h1C00_0000, byte base address of the bank.
- MAX_STARVE, 4, maximum consecutive requester-0 wins while a low-priority request is pending; legal range ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- req_i  in  NB_REQ  per-requester request
- add_i  in  NB_REQ x 32  byte address
- wen_i  in  NB_REQ  1=read, 0=write
- wdata_i  in  NB_REQ x 32  write data
- be_i  in  NB_REQ x 4  byte enables
- gnt_o  out  NB_REQ  grant, one-hot or zero
- r_valid_o  out  NB_REQ  response valid
- r_rdata_o  out  NB_REQ x 32  read data
- bank_req_o  out  1  SRAM request
- bank_we_o  out  1  SRAM write enable
- bank_addr_o  out  $clog2(BANK_WORDS)  SRAM word address
- bank_wdata_o  out  32  SRAM write data
- bank_be_o  out  4  SRAM byte enables
- bank_rdata_i  in  32  SRAM read data, valid the cycle after bank_req_o
- conflict_cnt_o  out  32  saturating count of cycles with ≥2 requests pending

Behaviour:
- Reset and clock: reset rst_ni, asynchronous, active-low; clock clk_i.
- Registered state reset values:
  - r_valid_o = 0
  - rr_ptr = 1
  - starve_cnt = 0
  - owner = 0
  - conflict_cnt_o = 0
- Grant path is combinational, same cycle as req_i.
  - At most one gnt_o bit is high.
  - bank_req_o = |gnt_o.
  - No request → all gnt_o = 0, bank_req_o = 0.
- Arbitration order per cycle:
  - lo_pending = |req_i[NB_REQ-1:1].
  - RR winner = first requester k≥1 with req_i[k], searching from rr_ptr upward and wrapping NB_REQ-1 → 1.
  - If req_i[0] && !(lo_pending && starve_cnt==MAX_STARVE), grant requester 0.
  - Else if lo_pending, grant the RR winner.
- rr_ptr update:
  - On a grant to k≥1: rr_ptr ← k+1, or 1 if k==NB_REQ-1.
  - Otherwise unchanged.
- starve_cnt update:
  - Increment (never beyond MAX_STARVE) when requester 0 is granted and lo_pending.
  - Clear when a k≥1 is granted or !lo_pending.
- Bank mux, driven from the granted requester:
  - bank_we_o = ~wen_i[g]
  - bank_addr_o = (add_i[g] − BASE_ADDR)[$clog2(BANK_WORDS)+1:2]
  - bank_wdata_o = wdata_i[g], bank_be_o = be_i[g]
  - No range check; bits above the index are discarded and the address wraps modulo bank size.
  - When idle, the mux outputs are don't-care but must be stable: hold requester 0's fields.
- Response:
  - owner ← g on any grant.
  - r_valid_o is one-hot on owner exactly 1 cycle after the grant, for reads and writes alike.
  - r_rdata_o[i] = bank_rdata_i for all i; only the owner's r_valid qualifies it.
  - Back-to-back grants to different requesters give back-to-back r_valid to the respective owners.
- Throughput: one access per cycle, no bubbles.
- conflict_cnt_o increments when popcount(req_i) ≥ 2; saturates at 32'hFFFF_FFFF.
- Reset mid-operation: a pending r_valid is dropped; arbitration restarts from rr_ptr=1 and starve_cnt=0.

Test Plan:
- Single requester 1 writes 0xDEADBEEF to BASE_ADDR+0x10 with be=4'hF, then reads it back → bank_addr_o=4; gnt same cycle; r_valid_o[1] the next cycle; r_rdata=0xDEADBEEF.
- req_i=3'b110 held for 4 cycles → grants 1,2,1,2; r_valid follows one cycle later each time; conflict_cnt_o=4.
- req_i=3'b011 held continuously with MAX_STARVE=4 → grant sequence 0,0,0,0,1,0,0,0,0,1…; starve_cnt returns to 0 after each grant to 1.
- Address BASE_ADDR+4*BANK_WORDS+8 from requester 2 → bank_addr_o=2 (wrap); r_valid_o[2] only.
- Assert rst_ni low in the cycle after a read grant → r_valid_o stays 0; after reset, req_i=3'b110 grants requester 1 first.
- Idle cycles (req_i=0) → gnt_o=0, bank_req_o=0, r_valid_o=0 the next cycle, counters unchanged.
